// File: rtl/kernel_rf_pkg.sv
// Shared types and default sizing for the double-buffered kernel register-file controller.
package kernel_rf_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 512;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_FILL = 2'd1,
    L_FULL = 2'd2
  } ld_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/kernel_rf_bank.sv
// Behavioural single-port RF, active-low CEN/WEN, registered read; drop-in stand-in for the compiled macro.
module kernel_rf_bank
  import kernel_rf_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              cen,
  input  logic              wen,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and read register have no reset; a macro cannot clear its contents either.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[addr] <= wdata;
      else      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/kernel_rf_pingpong_ctrl.sv
// Ping/pong kernel RF controller: streaming loader fills one bank while the reader bursts the other.
// Define KERNEL_RF_RD_REG_EN to add an output register on rd_data/rd_valid/rd_last (one extra cycle of latency).
module kernel_rf_pingpong_ctrl
  import kernel_rf_pkg::*;
#(
  parameter int  NUM_CH = DEF_NUM_CH,
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_start,
  input  logic [AW:0]              ld_len,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [NUM_CH*DATA_W-1:0] ld_data,
  output logic                     ld_full,
  input  logic                     swap_req,
  output logic                     swap_ack,
  input  logic                     rd_start,
  input  logic [AW-1:0]            rd_base,
  input  logic [AW:0]              rd_len,
  output logic                     rd_busy,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_last
);

  localparam int          W       = NUM_CH * DATA_W;
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  ld_state_t     ld_state;
  logic [AW:0]   ld_len_q;
  logic [AW-1:0] wr_addr;
  logic          wr_bank;

  rd_state_t     rd_state;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_rem;

  logic wr_fire, rd_issue, swap_go;

  assign wr_fire  = (ld_state == L_FILL) && ld_valid;
  assign rd_issue = (rd_state == R_RUN);
  assign swap_go  = (ld_state == L_FULL) && (rd_state == R_IDLE) && swap_req;

  assign ld_ready = (ld_state == L_FILL);
  assign ld_full  = (ld_state == L_FULL);
  assign rd_busy  = rd_issue;

  // NOTE: all state here uses <= so every branch sees pre-edge values, e.g. wr_addr in the last-word compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state <= L_IDLE;
      ld_len_q <= '0;
      wr_addr  <= '0;
      wr_bank  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= swap_go;
      unique case (ld_state)
        L_IDLE: if (ld_start) begin
          ld_len_q <= ld_len;
          wr_addr  <= '0;
          ld_state <= (ld_len == '0) ? L_FULL : L_FILL;
        end
        L_FILL: if (ld_valid) begin
          wr_addr <= wr_addr + AW'(1);
          if ({1'b0, wr_addr} == ld_len_q - LEN_ONE) ld_state <= L_FULL;
        end
        L_FULL: if (swap_go) begin
          wr_bank  <= ~wr_bank;
          ld_state <= L_IDLE;
        end
        default: ld_state <= L_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_rem   <= '0;
    end else if (rd_state == R_IDLE) begin
      if (rd_start && (rd_len != '0)) begin
        rd_addr  <= rd_base;
        rd_rem   <= rd_len;
        rd_state <= R_RUN;
      end
    end else begin
      rd_addr <= rd_addr + AW'(1);   // wraps modulo DEPTH since DEPTH is a power of two
      rd_rem  <= rd_rem - LEN_ONE;
      if (rd_rem == LEN_ONE) rd_state <= R_IDLE;
    end
  end

  // Tracks the RF read in flight; the bank is captured because a swap may land as the data returns.
  logic p1_valid, p1_last, p1_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p1_bank  <= 1'b0;
    end else begin
      p1_valid <= rd_issue;
      p1_last  <= rd_issue && (rd_rem == LEN_ONE);
      p1_bank  <= ~wr_bank;
    end
  end

  logic [1:0]        bank_cen, bank_wen;
  logic [AW-1:0]     bank_addr  [2];
  logic [DATA_W-1:0] bank_rdata [2][NUM_CH];

  // NOTE: every output gets a value on every path of this block, so no latch can be inferred.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (1'(b) == wr_bank) begin
        bank_cen[b]  = ~wr_fire;
        bank_wen[b]  = ~wr_fire;
        bank_addr[b] = wr_addr;
      end else begin
        bank_cen[b]  = ~rd_issue;
        bank_wen[b]  = 1'b1;
        bank_addr[b] = rd_addr;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      kernel_rf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rf (
        .clk   (clk),
        .cen   (bank_cen[b]),
        .wen   (bank_wen[b]),
        .addr  (bank_addr[b]),
        .wdata (ld_data[c*DATA_W +: DATA_W]),
        .rdata (bank_rdata[b][c])
      );
    end
  end

  logic [W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) rd_word[c*DATA_W +: DATA_W] = bank_rdata[p1_bank][c];
  end

`ifdef KERNEL_RF_RD_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= p1_valid;
      rd_last  <= p1_valid && p1_last;
      rd_data  <= p1_valid ? rd_word : '0;
    end
  end
`else
  // Gated so rd_data reads as zero whenever no word is being presented, including out of reset.
  assign rd_valid = p1_valid;
  assign rd_last  = p1_valid && p1_last;
  assign rd_data  = p1_valid ? rd_word : '0;
`endif

endmodule

// File: tb/tb_kernel_rf_pingpong_ctrl.sv
// Self-checking bench: randomized directed steps against a cycle-level scoreboard of the bank/burst rules.
module tb_kernel_rf_pingpong_ctrl;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam int AW     = $clog2(DEPTH);
  localparam int W      = NUM_CH * DATA_W;
`ifdef KERNEL_RF_RD_REG_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n, ld_start, ld_valid, swap_req, rd_start;
  logic [AW:0]   ld_len, rd_len;
  logic [AW-1:0] rd_base;
  logic [W-1:0]  ld_data;
  logic          ld_ready, ld_full, swap_ack, rd_busy, rd_valid, rd_last;
  logic [W-1:0]  rd_data;

  kernel_rf_pingpong_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_full(ld_full), .swap_req(swap_req),
    .swap_ack(swap_ack), .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: bank contents, loader progress, and a queue of words due at given cycles.
  typedef struct {
    int           cyc;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic [W-1:0] mem [2][DEPTH];
  exp_t         rq[$];
  int           cyc = 0, busy_end = 0, m_wb = 0, m_len = 0, m_waddr = 0;
  logic         m_ready = 1'b0, m_full = 1'b0, exp_ack = 1'b0;

  task automatic model_reset();
    rq.delete();
    busy_end = 0;
    m_wb     = 0;
    m_ready  = 1'b0;
    m_full   = 1'b0;
    exp_ack  = 1'b0;
  endtask

  // One clock: apply the spec rules to the inputs as driven, advance, then compare every output.
  task automatic tick();
    logic hs, idle_ld, grant, acc;
    exp_t e;
    hs      = ld_valid && m_ready;
    idle_ld = !m_ready && !m_full;
    grant   = m_full && (cyc >= busy_end) && swap_req;
    acc     = rd_start && (cyc >= busy_end) && (rd_len != 0);
    if (hs) begin
      mem[m_wb][m_waddr] = ld_data;
      m_waddr++;
      if (m_waddr == m_len) begin m_ready = 1'b0; m_full = 1'b1; end
    end
    if (idle_ld && ld_start) begin
      m_len   = int'(ld_len);
      m_waddr = 0;
      if (ld_len == 0) m_full = 1'b1; else m_ready = 1'b1;
    end
    if (grant) begin m_wb = 1 - m_wb; m_full = 1'b0; m_ready = 1'b0; end
    exp_ack = grant;
    if (acc) begin
      for (int k = 0; k < int'(rd_len); k++) begin
        e.cyc  = cyc + RD_LAT + k;
        e.data = mem[1 - m_wb][(int'(rd_base) + k) % DEPTH];
        e.last = (k == int'(rd_len) - 1);
        rq.push_back(e);
      end
      busy_end = cyc + 1 + int'(rd_len);
    end
    @(posedge clk);
    #1;
    cyc++;
    check("ld_ready", W'(ld_ready), W'(m_ready));
    check("ld_full", W'(ld_full), W'(m_full));
    check("swap_ack", W'(swap_ack), W'(exp_ack));
    check("rd_busy", W'(rd_busy), W'(cyc < busy_end));
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      e = rq.pop_front();
      check("rd_valid", W'(rd_valid), W'(1));
      check("rd_last", W'(rd_last), W'(e.last));
      check("rd_data", rd_data, e.data);
    end else begin
      check("rd_valid", W'(rd_valid), W'(0));
      check("rd_last", W'(rd_last), W'(0));
      check("rd_data", rd_data, W'(0));
    end
  endtask

  task automatic burst(input int base, input int len);
    rd_start = 1'b1; rd_base = AW'(base); rd_len = (AW+1)'(len);
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 40 && !swap_ack; i++) tick();
    check(tag, W'(swap_ack), W'(1));
    swap_req = 1'b0;
  endtask

  initial begin
    int rdy_cnt;
    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; swap_req = 1'b0; rd_start = 1'b0;
    ld_len = '0; rd_len = '0; rd_base = '0; ld_data = '0;
    #2;
    check("rst_outputs", W'({ld_ready, ld_full, swap_ack, rd_busy, rd_valid, rd_last}), W'(0));
    check("rst_rd_data", rd_data, W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load 9 words with ld_valid held high; ch0 carries 0..8.
    ld_start = 1'b1; ld_len = 10'd9; ld_valid = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      ld_data = {$urandom(), $urandom()};
      ld_data[DATA_W-1:0] = DATA_W'(m_waddr);
      tick();
      ld_start = 1'b0;
      if (ld_ready) rdy_cnt++;
    end
    ld_valid = 1'b0;
    check("ld_ready_cycles", W'(rdy_cnt), W'(9));
    check("ld_full_after_9", W'(ld_full), W'(1));

    swap_req = 1'b1;
    wait_ack("swap_ack_first");

    // Fill bank 1 completely with bursty ld_valid while random bursts read bank 0.
    ld_start = 1'b1; ld_len = 10'd512;
    for (int i = 0; i < 4000 && !m_full; i++) begin
      int base;
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = {$urandom(), $urandom()};
      base     = $urandom_range(0, 8);
      rd_start = ($urandom_range(0, 3) == 0);
      rd_base  = AW'(base);
      rd_len   = (AW+1)'($urandom_range(0, 9 - base));
      tick();
      ld_start = 1'b0;
    end
    ld_valid = 1'b0; rd_start = 1'b0;
    check("fill_512_done", W'(ld_full), W'(1));
    repeat (RD_LAT + 10) tick();

    // Swap requested during a burst is held off until the reader is idle.
    burst(0, 9);
    swap_req = 1'b1;
    tick();
    check("no_ack_while_busy", W'(swap_ack), W'(0));
    wait_ack("swap_ack_after_burst");
    repeat (2) tick();

    // Wrap-around burst on bank 1: 510, 511, 0, 1.
    burst(510, 4);
    repeat (RD_LAT + 4) tick();
    burst(37, 0);
    repeat (3) tick();

    // Zero-length load, then grant and rd_start in the same cycle read the new read bank.
    ld_start = 1'b1; ld_len = '0;
    tick();
    ld_start = 1'b0;
    check("ld_full_len0", W'(ld_full), W'(1));
    swap_req = 1'b1;
    burst(0, 9);
    wait_ack("swap_ack_with_start");
    repeat (RD_LAT + 9) tick();

    // Partial load, then reset in the middle of a burst.
    ld_start = 1'b1; ld_len = 10'd3; ld_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_data = {$urandom(), $urandom()};
      tick();
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
    burst(0, 9);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_rd_valid", W'(rd_valid), W'(0));
    check("rst_mid_rd_busy", W'(rd_busy), W'(0));
    check("rst_mid_ld_full", W'(ld_full), W'(0));
    check("rst_mid_rd_data", rd_data, W'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    // Bank contents survive reset; read bank is 1 again.
    burst(0, 4);
    repeat (RD_LAT + 4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
